sync_fifo_wr_arbiter: RTL and testbench

- Shares the 64-bit write port of the 64-to-256 width-converting sync FIFO between N_REQ requesters.
- One 256-bit output word is built from 4 consecutive 64-bit writes, so writes are granted in atomic 4-beat bursts. Beats from different requesters never interleave inside one output word.
- Tracks FIFO occupancy locally (mirror count) and grants a burst only when 4 free slots exist. A granted burst can therefore never see full.
- Sits directly in front of the FIFO write side; observes the read side for occupancy.

---
 rtl/sync_fifo_wr_arbiter_pkg.sv | 19 +
 rtl/sync_fifo_wr_arbiter_rr.sv | 31 +++
 rtl/sync_fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared definitions for the 4-beat burst write arbiter in front of the 64-to-256 sync FIFO.
package sync_fifo_wr_arbiter_pkg;

    localparam int BEATS      = 4;
    localparam int BEAT_CNT_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping around.
module rr_arbiter_onehot
    import sync_fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    always_comb begin
        int cand;
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        cand        = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!pick_any && req[IDX_W'(cand)]) begin
                pick_any                   = 1'b1;
                pick_onehot[IDX_W'(cand)]  = 1'b1;
                pick_idx                   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Grants the FIFO 64-bit write port to one requester at a time in atomic 4-beat bursts,
// only when a local mirror of FIFO occupancy shows room for a whole burst.
module sync_fifo_wr_arbiter
    import sync_fifo_wr_arbiter_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int DATA_WIDTH_I = 64,
    parameter  int FIFO_DEPTH   = 8,
    localparam int IDX_W        = idx_w(N_REQ),
    localparam int OCC_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH_I-1:0] req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic [N_REQ-1:0]              gnt,
    output logic [IDX_W-1:0]              gnt_id,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH_I-1:0]       fifo_din,
    input  logic                          fifo_full,
    input  logic                          fifo_rd,
    input  logic                          fifo_empty,
    output logic [OCC_W-1:0]              occ
);

    localparam logic [OCC_W-1:0]      OCC_SPACE_MAX = OCC_W'(FIFO_DEPTH - BEATS);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT     = BEAT_CNT_W'(BEATS - 1);

    state_e                state;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  rd_vld;
    logic                  space_ok;
    logic [OCC_W-1:0]      occ_next;
    logic [N_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    // A read pops a whole output word (BEATS entries); clamp keeps the mirror in range.
    function automatic logic [OCC_W-1:0] sat_occ(input logic [OCC_W-1:0] cur,
                                                 input logic wr, input logic rd);
        int sum;
        sum = int'(cur) + int'(wr) - (rd ? BEATS : 0);
        if (sum < 0) begin
            sum = 0;
        end else if (sum > FIFO_DEPTH) begin
            sum = FIFO_DEPTH;
        end
        return OCC_W'(sum);
    endfunction

    rr_arbiter_onehot #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req        (req_valid),
        .ptr        (gnt_id),
        .pick_onehot(pick_onehot),
        .pick_idx   (pick_idx),
        .pick_any   (pick_any)
    );

    assign rd_vld   = fifo_rd & ~fifo_empty;
    assign occ_next = sat_occ(occ, fifo_wr, rd_vld);
    assign space_ok = (occ_next <= OCC_SPACE_MAX);

    always_comb begin
        req_ready = '0;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
        if (state == BURST) begin
            req_ready[gnt_id] = ~fifo_full;
            fifo_wr           = req_valid[gnt_id] & ~fifo_full;
            fifo_din          = req_data[int'(gnt_id)*DATA_WIDTH_I +: DATA_WIDTH_I];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= IDX_W'(N_REQ - 1);
            beat_cnt <= '0;
            occ      <= '0;
        end else begin
            occ <= occ_next;
            unique case (state)
                IDLE: begin
                    if (pick_any && space_ok) begin
                        gnt      <= pick_onehot;
                        gnt_id   <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // Grant is held until all beats land, however long the requester stalls.
                    if (fifo_wr) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_sync_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int NB    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    gnt;
    logic [1:0]      gnt_id;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic            fifo_full;
    logic            fifo_rd;
    logic            fifo_empty;
    logic [3:0]      occ;

    always #5 clk = ~clk;

    sync_fifo_wr_arbiter #(
        .N_REQ(N), .DATA_WIDTH_I(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .gnt(gnt), .gnt_id(gnt_id), .fifo_wr(fifo_wr),
        .fifo_din(fifo_din), .fifo_full(fifo_full), .fifo_rd(fifo_rd),
        .fifo_empty(fifo_empty), .occ(occ)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: burst owner (-1 = none), beats taken, round-robin pointer, occupancy.
    int          m_owner = -1;
    int          m_beats = 0;
    int          m_ptr   = N - 1;
    int          m_occ   = 0;
    logic [63:0] q[$];
    int          seq[N];
    logic [N-1:0] acc_s = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_gnt, e_rdy;
        logic         e_wr;
        logic [63:0]  e_din, w0, wj;
        bit           rd_ok, found;
        int           occ_n, k;
        e_gnt = '0; e_rdy = '0; e_wr = 1'b0; e_din = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            if (!fifo_full) e_rdy[m_owner] = 1'b1;
            e_wr  = req_valid[m_owner] && !fifo_full;
            e_din = req_data[m_owner*DW +: DW];
            chk("no_full_in_burst", fifo_full, 1'b0);
        end
        chk("gnt", gnt, e_gnt);
        chk("gnt_id", gnt_id, m_ptr);
        chk("req_ready", req_ready, e_rdy);
        chk("fifo_wr", fifo_wr, e_wr);
        chk("occ", occ, m_occ);
        if (e_wr) chk("fifo_din", fifo_din, e_din);
        acc_s = req_valid & req_ready;

        if (rst) begin
            m_owner = -1; m_beats = 0; m_ptr = N - 1; m_occ = 0;
            q.delete();
        end else begin
            rd_ok = fifo_rd && !fifo_empty;
            if (rd_ok && q.size() >= NB) begin
                // One output word must be four consecutive beats of one requester.
                w0 = q.pop_front();
                for (int j = 1; j < NB; j++) begin
                    wj = q.pop_front();
                    chk("word_group", wj, {w0[63:56], 56'(w0[55:0] + 56'(j))});
                end
            end
            if (fifo_wr) q.push_back(fifo_din);
            occ_n = m_occ + (e_wr ? 1 : 0) - (rd_ok ? NB : 0);
            if (occ_n < 0) occ_n = 0;
            if (occ_n > DEPTH) occ_n = DEPTH;
            if (m_owner < 0) begin
                found = 0;
                if (occ_n <= DEPTH - NB) begin
                    for (int i = 1; i <= N; i++) begin
                        k = (m_ptr + i) % N;
                        if (!found && req_valid[k]) begin
                            found = 1; m_owner = k; m_ptr = k; m_beats = 0;
                        end
                    end
                end
            end else if (e_wr) begin
                m_beats++;
                if (m_beats == NB) m_owner = -1;
            end
            m_occ = occ_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc_s[k]) seq[k]++;
            req_data[k*DW +: DW] = {8'(k), 56'(seq[k])};
        end
        fifo_empty = (q.size() < NB);
        fifo_full  = (q.size() >= DEPTH);
        fifo_rd    = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int          order[$];
    int          exp_ord[4] = '{1, 3, 1, 3};
    logic [N-1:0] prev_gnt;

    initial begin
        rst = 1'b1; req_valid = '0; fifo_rd = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        for (int k = 0; k < N; k++) seq[k] = 0;
        seq[0] = 32'h11;
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = {8'(k), 56'(seq[k])};
        step(); step();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_gnt_id", gnt_id, 2'd3);
        chk("rst_occ", occ, 0);
        chk("rst_fifo_wr", fifo_wr, 1'b0);
        chk("rst_fifo_din", fifo_din, 64'h0);
        chk("rst_req_ready", req_ready, 4'b0000);
        rst = 1'b0;

        // Single requester, data 0x11..0x14
        req_valid = 4'b0001;
        step(); chk("t1_gnt", gnt, 4'b0001); chk("t1_wr", fifo_wr, 1'b1); chk("t1_din0", fifo_din, 64'h11);
        step(); chk("t1_din1", fifo_din, 64'h12); chk("t1_occ1", occ, 1);
        step(); chk("t1_din2", fifo_din, 64'h13);
        step(); chk("t1_din3", fifo_din, 64'h14); chk("t1_occ3", occ, 3);
        step(); chk("t1_gnt_drop", gnt, 4'b0000); chk("t1_occ4", occ, 4); chk("t1_wr_idle", fifo_wr, 1'b0);
        req_valid = 4'b0000;

        // All requesters, no reads until full
        do_reset();
        req_valid = 4'b1111;
        step(); chk("t2_gnt0", gnt, 4'b0001);
        repeat (4) step();
        chk("t2_bubble", gnt, 4'b0000);
        step(); chk("t2_gnt1", gnt, 4'b0010);
        repeat (4) step();
        chk("t2_occ8", occ, 8);
        step(); step();
        chk("t2_hold", gnt, 4'b0000);
        fifo_rd = 1'b1;
        step(); chk("t2_occ_after_rd", occ, 4); chk("t2_gnt2", gnt, 4'b0100); chk("t2_gnt_id2", gnt_id, 2'd2);
        repeat (4) step();
        req_valid = 4'b0000;

        // Round-robin between req1 and req3 with reads keeping space
        do_reset();
        req_valid = 4'b1010;
        prev_gnt = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (gnt != 0 && gnt != prev_gnt) order.push_back(int'(gnt_id));
            prev_gnt = gnt;
            fifo_rd = (q.size() >= NB);
        end
        for (int i = 0; i < 4; i++) chk("t3_order", (i < order.size()) ? order[i] : 99, exp_ord[i]);
        req_valid = 4'b0000;

        // Mid-burst stall of req2 while req0 waits
        do_reset();
        req_valid = 4'b0100;
        step(); chk("t4_gnt", gnt, 4'b0100); chk("t4_wr", fifo_wr, 1'b1);
        req_valid = 4'b0101;
        step();
        step();
        req_valid = 4'b0001; #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            chk("t4_hold_gnt", gnt, 4'b0100);
            chk("t4_ready", req_ready, 4'b0100);
            chk("t4_stall_wr", fifo_wr, 1'b0);
        end
        step();
        req_valid = 4'b0101; #1;
        chk("t4_beat3", fifo_wr, 1'b1);
        step(); chk("t4_beat4", fifo_wr, 1'b1);
        step(); chk("t4_bubble", gnt, 4'b0000); chk("t4_occ", occ, 4);
        req_valid = 4'b0001;
        step(); chk("t4_next_gnt", gnt, 4'b0001);

        // Concurrent read and write, then read while empty
        fifo_rd = 1'b1;
        step(); chk("t5_occ_rw", occ, 1);
        fifo_rd = 1'b1;
        step(); chk("t5_occ_rd_empty", occ, 2);

        // Reset mid-burst
        req_valid = 4'b0101;
        rst = 1'b1;
        step(); chk("t6_gnt", gnt, 4'b0000); chk("t6_occ", occ, 0); chk("t6_wr", fifo_wr, 1'b0);
        rst = 1'b0;
        step(); chk("t6_first_gnt", gnt, 4'b0001);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
            fifo_rd = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
